// File: rtl/tag_rx_sched.sv
// Tag receive burst scheduler: sync preamble, armed capture windows, guard gaps.
// Optional abort input when TAG_RX_SCHED_ABORT_EN is defined.
module tag_rx_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 24,
  parameter int NREP_WIDTH = 8,
  parameter int SYNC_LEN   = 8192,
  parameter int GUARD_LEN  = 1024,
  parameter int SYNC_AMP   = 16384
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  trig_in,
`ifdef TAG_RX_SCHED_ABORT_EN
  input  logic                  abort,
`endif
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [NREP_WIDTH-1:0] cfg_nrep,
  input  logic [CNT_WIDTH-1:0]  cfg_win_len,
  input  logic                  sync_ready,
  output logic                  rx_srst,
  output logic                  out_sel,
  output logic [DATA_WIDTH-1:0] isync,
  output logic [DATA_WIDTH-1:0] qsync,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [2:0]            state,
  output logic [NREP_WIDTH-1:0] rep_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRE_P = 3'd1,
    PRE_N = 3'd2,
    ARM   = 3'd3,
    CAPT  = 3'd4,
    GUARD = 3'd5,
    DONE  = 3'd6
  } state_t;

  // One shared phase counter, wide enough for every timed state
  localparam int SW  = $clog2(SYNC_LEN + 1);
  localparam int GW  = $clog2(GUARD_LEN + 1);
  localparam int CW0 = (SW > GW) ? SW : GW;
  localparam int CW  = (CW0 > CNT_WIDTH) ? CW0 : CNT_WIDTH;

  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_LEN - 1);
  localparam logic [CW-1:0] GUARD_LAST =
    CW'((GUARD_LEN > 0) ? GUARD_LEN - 1 : 0);

  localparam logic [DATA_WIDTH-1:0] AMP_P = DATA_WIDTH'(SYNC_AMP);
  localparam logic [DATA_WIDTH-1:0] AMP_N = DATA_WIDTH'(-SYNC_AMP);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NREP_WIDTH-1:0] rep_q, rep_d;
  logic [NREP_WIDTH-1:0] nrep_q;
  logic [CNT_WIDTH-1:0]  win_q;
  logic [CNT_WIDTH-1:0]  win_last;
  logic [NREP_WIDTH-1:0] rep_inc;
  logic                  terr_q, terr_d;
  logic                  trig_q;
  logic                  trig_rise;
  logic                  srst_q;
  logic                  cap_hit;
  logic                  last_rep;

  assign trig_rise = trig_in & ~trig_q;
  assign win_last  = win_q - 1'b1;
  assign cap_hit   = sync_ready | (cnt_q == CW'(win_last));
  assign rep_inc   = (&rep_q) ? rep_q : rep_q + 1'b1;
  assign last_rep  =
    ({1'b0, rep_q} + 1'b1) == {1'b0, nrep_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    rep_d   = rep_q;
    terr_d  = terr_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trig_rise && nrep_q != '0) begin
          state_d = PRE_P;
          rep_d   = '0;
          terr_d  = 1'b0;
        end
      end
      PRE_P: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = PRE_N;
          cnt_d   = '0;
        end
      end
      PRE_N: begin
        if (cnt_q == SYNC_LAST) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      ARM: begin
        state_d = CAPT;
        cnt_d   = '0;
      end
      CAPT: begin
        // A sync_ready on the final window cycle wins over the timeout
        if (cap_hit) begin
          rep_d  = rep_inc;
          terr_d = terr_q | ~sync_ready;
          cnt_d  = '0;
          if (last_rep)
            state_d = DONE;
          else
            state_d = (GUARD_LEN == 0) ? ARM : GUARD;
        end
      end
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = ARM;
          cnt_d   = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
`ifdef TAG_RX_SCHED_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cnt_d   = '0;
      rep_d   = rep_q;
      terr_d  = terr_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rep_q   <= '0;
      terr_q  <= 1'b0;
      trig_q  <= 1'b1;
      srst_q  <= 1'b0;
      nrep_q  <= NREP_WIDTH'(1);
      win_q   <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rep_q   <= rep_d;
      terr_q  <= terr_d;
      trig_q  <= trig_in;
      srst_q  <= (state_d == ARM);
      if (cfg_valid && cfg_ready) begin
        nrep_q <= cfg_nrep;
        win_q  <= (cfg_win_len == '0) ?
                  CNT_WIDTH'(1) : cfg_win_len;
      end
    end
  end

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rx_valid    = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign out_sel     = (state_q == PRE_P) | (state_q == PRE_N);
  assign isync       = (state_q == PRE_P) ? AMP_P :
                       (state_q == PRE_N) ? AMP_N : '0;
  assign qsync       = '0;
  assign rx_srst     = srst_q;
  assign timeout_err = terr_q;
  assign state       = state_q;
  assign rep_cnt     = rep_q;

endmodule

// File: tb/tb_tag_rx_sched.sv
// Bench for tag_rx_sched: directed vector table, corner sequences,
// and random traffic against a behavioural burst model.
module tb_tag_rx_sched;

  localparam int SYNC  = 8;
  localparam int GUARD = 4;
  localparam int AMP   = 16384;
`ifdef TAG_RX_SCHED_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_PREP = 1, P_PREN = 2, P_ARM = 3;
  localparam int P_CAPT = 4, P_GUARD = 5, P_DONE = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig_in;
  logic        abort;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_nrep;
  logic [23:0] cfg_win_len;
  logic        sync_ready;
  logic        rx_srst;
  logic        out_sel;
  logic [15:0] isync;
  logic [15:0] qsync;
  logic        rx_valid;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic [2:0]  state;
  logic [7:0]  rep_cnt;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  tag_rx_sched #(
    .DATA_WIDTH(16), .CNT_WIDTH(24), .NREP_WIDTH(8),
    .SYNC_LEN(SYNC), .GUARD_LEN(GUARD), .SYNC_AMP(AMP)
  ) dut (
    .clk(clk), .reset(reset), .trig_in(trig_in),
`ifdef TAG_RX_SCHED_ABORT_EN
    .abort(abort),
`endif
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_nrep(cfg_nrep), .cfg_win_len(cfg_win_len),
    .sync_ready(sync_ready), .rx_srst(rx_srst),
    .out_sel(out_sel), .isync(isync), .qsync(qsync),
    .rx_valid(rx_valid), .busy(busy), .done(done),
    .timeout_err(timeout_err), .state(state),
    .rep_cnt(rep_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase plus cycles remaining in that phase
  int m_phase, m_left, m_rep, m_nrep, m_win;
  bit m_terr, m_prev;

  task automatic m_step(input bit trig, input bit cfgv,
                        input int nrep, input int win,
                        input bit sr, input bit ab, input bit rst);
    bit rise, go;
    if (rst) begin
      m_phase = P_IDLE; m_left = 0; m_rep = 0; m_terr = 0;
      m_nrep = 1; m_win = (1 << 24) - 1; m_prev = 1;
      return;
    end
    rise = trig && !m_prev;
    m_prev = trig;
    if (ABORT_EN && ab && m_phase != P_IDLE) begin
      m_phase = P_IDLE;
      return;
    end
    case (m_phase)
      P_IDLE: begin
        go = rise && m_nrep != 0;
        if (cfgv) begin m_nrep = nrep; m_win = win; end
        if (go) begin
          m_phase = P_PREP; m_left = SYNC; m_rep = 0; m_terr = 0;
        end
      end
      P_PREP: begin
        m_left--;
        if (m_left == 0) begin m_phase = P_PREN; m_left = SYNC; end
      end
      P_PREN: begin
        m_left--;
        if (m_left == 0) m_phase = P_ARM;
      end
      P_ARM: begin
        m_phase = P_CAPT;
        m_left = (m_win == 0) ? 1 : m_win;
      end
      P_CAPT: begin
        m_left--;
        if (sr || m_left == 0) begin
          if (!sr) m_terr = 1;
          if (m_rep < 255) m_rep++;
          if (m_rep == m_nrep) m_phase = P_DONE;
          else if (GUARD == 0) m_phase = P_ARM;
          else begin m_phase = P_GUARD; m_left = GUARD; end
        end
      end
      P_GUARD: begin
        m_left--;
        if (m_left == 0) m_phase = P_ARM;
      end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_model();
    int e_is;
    bit ok;
    e_is = (m_phase == P_PREP) ? AMP : (m_phase == P_PREN) ? -AMP : 0;
    ok = (state == 3'(m_phase)) &&
         (busy == (m_phase != P_IDLE)) &&
         (rx_valid == (m_phase != P_IDLE)) &&
         (cfg_ready == (m_phase == P_IDLE)) &&
         (done == (m_phase == P_DONE)) &&
         (rx_srst == (m_phase == P_ARM)) &&
         (out_sel == (m_phase == P_PREP || m_phase == P_PREN)) &&
         ($signed(isync) == e_is) && (qsync == 16'd0) &&
         (timeout_err == m_terr) && (rep_cnt == 8'(m_rep));
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL model cyc=%0d got st=%0d is=%0d q=%0d srst=%0b sel=%0b done=%0b terr=%0b rep=%0d rdy=%0b busy=%0b want st=%0d is=%0d terr=%0b rep=%0d",
               cyc, state, $signed(isync), qsync, rx_srst, out_sel,
               done, timeout_err, rep_cnt, cfg_ready, busy,
               m_phase, e_is, m_terr, m_rep);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  // Check the current cycle, drive this cycle's inputs, advance
  task automatic cyc1(input bit trig, input bit cfgv, input int nrep,
                      input int win, input bit sr, input bit ab,
                      input bit rst);
    check_model();
    trig_in = trig; cfg_valid = cfgv;
    cfg_nrep = 8'(nrep); cfg_win_len = 24'(win);
    sync_ready = sr; abort = ab; reset = rst;
    m_step(trig, cfgv, nrep, win, sr, ab, rst);
    @(negedge clk);
    cyc++;
  endtask

  task automatic burst(input bit disturb, output int dcyc);
    dcyc = -1;
    cyc1(1, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 40 && dcyc < 0; k++) begin
      if (k == 1) chk("terr_clear", timeout_err, 0);
      if (disturb && k == 10) chk("cfg_ready_busy", cfg_ready, 0);
      if (done) begin
        dcyc = k;
        chk("terr_at_done", timeout_err, 1);
      end
      cyc1(disturb && (k == 10 || k == 19), disturb && k == 10,
           3, 50, 0, 0, 0);
    end
  endtask

  typedef struct {
    int cyc; bit trig; bit sr; bit chk;
    int st; int is; bit srst; bit dn; int rep;
  } vec_t;

  vec_t tab[15];

  function automatic vec_t mk(int c, bit t, bit s, bit k, int st,
                              int is, bit sr_, bit d, int r);
    vec_t v;
    v.cyc = c; v.trig = t; v.sr = s; v.chk = k; v.st = st;
    v.is = is; v.srst = sr_; v.dn = d; v.rep = r;
    return v;
  endfunction

  initial begin
    int dc;
    tab[0]  = mk(2,  0, 0, 0, P_IDLE,  0,    0, 0, 0);
    tab[1]  = mk(10, 1, 0, 1, P_IDLE,  0,    0, 0, 0);
    tab[2]  = mk(11, 0, 0, 1, P_PREP,  AMP,  0, 0, 0);
    tab[3]  = mk(18, 0, 0, 1, P_PREP,  AMP,  0, 0, 0);
    tab[4]  = mk(19, 0, 0, 1, P_PREN,  -AMP, 0, 0, 0);
    tab[5]  = mk(26, 0, 0, 1, P_PREN,  -AMP, 0, 0, 0);
    tab[6]  = mk(27, 0, 0, 1, P_ARM,   0,    1, 0, 0);
    tab[7]  = mk(28, 0, 0, 1, P_CAPT,  0,    0, 0, 0);
    tab[8]  = mk(40, 0, 1, 1, P_CAPT,  0,    0, 0, 0);
    tab[9]  = mk(41, 0, 0, 1, P_GUARD, 0,    0, 0, 1);
    tab[10] = mk(44, 0, 0, 1, P_GUARD, 0,    0, 0, 1);
    tab[11] = mk(45, 0, 0, 1, P_ARM,   0,    1, 0, 1);
    tab[12] = mk(60, 0, 1, 1, P_CAPT,  0,    0, 0, 1);
    tab[13] = mk(61, 0, 0, 1, P_DONE,  0,    0, 1, 2);
    tab[14] = mk(62, 0, 0, 1, P_IDLE,  0,    0, 0, 2);

    reset = 1; trig_in = 0; abort = 0; cfg_valid = 0;
    cfg_nrep = 0; cfg_win_len = 0; sync_ready = 0;
    m_step(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    cyc1(0, 0, 0, 0, 0, 0, 1);
    cyc1(0, 0, 0, 0, 0, 0, 1);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_state", state, P_IDLE);

    // Directed burst: nrep=2, win_len=100
    cyc = 0;
    for (int c = 0; c <= 64; c++) begin
      bit t, s;
      t = 0; s = 0;
      foreach (tab[i]) begin
        if (tab[i].cyc == c) begin
          t = tab[i].trig; s = tab[i].sr;
          if (tab[i].chk) begin
            vectors++;
            if (state != 3'(tab[i].st) ||
                $signed(isync) != tab[i].is ||
                rx_srst != tab[i].srst || done != tab[i].dn ||
                rep_cnt != 8'(tab[i].rep)) begin
              miscompares++;
              $display("FAIL table cyc=%0d got st=%0d is=%0d srst=%0b done=%0b rep=%0d want st=%0d is=%0d srst=%0b done=%0b rep=%0d",
                       c, state, $signed(isync), rx_srst, done,
                       rep_cnt, tab[i].st, tab[i].is, tab[i].srst,
                       tab[i].dn, tab[i].rep);
            end
          end
        end
      end
      cyc1(t, c == 2, 2, 100, s, 0, 0);
    end

    // Timeout window, then disturbances while busy
    cyc1(0, 1, 1, 5, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    burst(0, dc);
    chk("timeout_done_lat", dc, 23);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    chk("terr_sticky", timeout_err, 1);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    burst(1, dc);
    chk("disturb_done_lat", dc, 23);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    burst(0, dc);
    chk("cfg_kept_done_lat", dc, 23);
    cyc1(0, 0, 0, 0, 0, 0, 0);

    // nrep=0 ignores the trigger
    cyc1(0, 1, 0, 7, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    cyc1(1, 0, 0, 0, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0, 0, 0);
    chk("nrep0_idle", state, P_IDLE);
    chk("nrep0_busy", busy, 0);

    // Reset during CAPT
    cyc1(0, 1, 1, 100, 0, 0, 0);
    cyc1(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 19; k++) cyc1(0, 0, 0, 0, 0, 0, 0);
    chk("pre_rst_capt", state, P_CAPT);
    cyc1(0, 0, 0, 0, 0, 0, 1);
    chk("rst_mid_state", state, P_IDLE);
    chk("rst_mid_valid", rx_valid, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ready", cfg_ready, 1);
    cyc1(0, 0, 0, 0, 0, 0, 0);

    if (ABORT_EN) begin
      int g;
      g = 0;
      cyc1(0, 1, 2, 5, 0, 0, 0);
      cyc1(1, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 60 && state != 3'(P_GUARD); k++)
        cyc1(0, 0, 0, 0, 0, 0, 0);
      chk("abort_reach_guard", state, P_GUARD);
      cyc1(0, 0, 0, 0, 0, 1, 0);
      chk("abort_state", state, P_IDLE);
      chk("abort_done", done, 0);
      chk("abort_valid", rx_valid, 0);
      chk("abort_rep", rep_cnt, 1);
      g++;
      cyc1(0, 0, 0, 0, 0, 0, 0);
    end

    // Random traffic against the model
    for (int k = 0; k < 4000; k++) begin
      cyc1($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 3), $urandom_range(0, 12),
           $urandom_range(0, 11) == 0,
           ABORT_EN && $urandom_range(0, 59) == 0,
           $urandom_range(0, 399) == 0);
    end
    check_model();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tag_rx_sched.md
TAG_RX_SCHED -- requirements
Module: tag_rx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of the sync-tone I/Q outputs.
REQ-002 SHALL have parameter CNT_WIDTH, default 24, width of the capture-window length and counter.
REQ-003 SHALL have parameter NREP_WIDTH, default 8, width of the repetition count.
REQ-004 SHALL have parameter SYNC_LEN, default 8192, cycles per preamble half.
REQ-005 SHALL have parameter GUARD_LEN, default 1024, idle cycles between capture windows.
REQ-006 SHALL have parameter SYNC_AMP, default 16384, preamble I amplitude in signed two's complement.
REQ-007 SHALL have ports, in this order:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- trig_in  in  1  synchronized GPIO sync trigger (level)
- cfg_valid  in  1  config offer
- cfg_ready  out  1  config accepted when high with cfg_valid
- cfg_nrep  in  NREP_WIDTH  number of capture windows
- cfg_win_len  in  CNT_WIDTH  capture timeout, in cycles
- sync_ready  in  1  end-of-window pulse from RX demod
- rx_srst  out  1  one-cycle demod restart
- out_sel  out  1  1 = output sync tone, 0 = output demod
- isync  out  DATA_WIDTH  sync tone I
- qsync  out  DATA_WIDTH  sync tone Q
- rx_valid  out  1  burst active
- busy  out  1  not IDLE
- done  out  1  one-cycle burst-complete pulse
- timeout_err  out  1  sticky window timeout
- state  out  3  FSM state encoding
- rep_cnt  out  NREP_WIDTH  completed windows

Function
REQ-008 SHALL implement states: IDLE=0, PRE_P=1, PRE_N=2, ARM=3, CAPT=4, GUARD=5, DONE=6.
REQ-009 SHALL drive cfg_ready=1 only in IDLE, and SHALL latch cfg_nrep and cfg_win_len when cfg_valid&cfg_ready; latched values SHALL be 1 and 2^CNT_WIDTH-1 after reset.
REQ-010 SHALL detect the trig_in rising edge with a registered previous sample; in IDLE with latched nrep!=0, an edge at cycle t SHALL put the FSM in PRE_P at t+1, clear rep_cnt and clear timeout_err.
REQ-011 SHALL ignore trig_in edges outside IDLE, and in IDLE when latched nrep==0.
REQ-012 SHALL hold PRE_P and PRE_N for exactly SYNC_LEN cycles each, with isync=+SYNC_AMP in PRE_P and -SYNC_AMP in PRE_N.
REQ-013 SHALL drive qsync=0 at all times, out_sel=1 only in PRE_P/PRE_N, and isync=0 in all other states.
REQ-014 SHALL hold ARM for one cycle with rx_srst=1 (registered, asserted exactly during ARM), then enter CAPT.
REQ-015 SHALL leave CAPT on the first sync_ready or after win_len cycles, whichever occurs first; on timeout without sync_ready, timeout_err SHALL set; if both occur in the same cycle, the exit SHALL count as normal.
REQ-016 SHALL increment rep_cnt on CAPT exit (saturating, no wrap), then go to DONE if rep_cnt+1==nrep, else GUARD.
REQ-017 SHALL hold GUARD for GUARD_LEN cycles, then return to ARM; GUARD_LEN=0 SHALL go straight to ARM.
REQ-018 SHALL pulse done for the single DONE cycle, then return to IDLE.
REQ-019 SHALL drive rx_valid=1 from PRE_P entry through the DONE cycle inclusive; busy SHALL be (state!=IDLE).
REQ-020 SHALL ignore sync_ready outside CAPT.
REQ-021 SHALL treat cfg_win_len=0 as 1.

Reset
REQ-022 SHALL set on reset: state=IDLE, all counters=0, rx_srst=0, out_sel=0, isync=qsync=0, rx_valid=0, busy=0, done=0, timeout_err=0, cfg_ready=1, edge register=1 (so a held-high trig_in does not fire after reset).
REQ-023 SHALL abandon any operation when reset is asserted mid-burst, with no done pulse.

Configuration
REQ-024 With TAG_RX_SCHED_ABORT_EN defined, SHALL add input abort (1 bit, after trig_in); abort=1 in any non-IDLE state SHALL force IDLE next cycle, deassert rx_srst/out_sel/rx_valid, keep rep_cnt, and emit no done.
REQ-025 Without TAG_RX_SCHED_ABORT_EN, the abort port SHALL be absent and behaviour SHALL be otherwise identical.

Verification (SYNC_LEN=8, GUARD_LEN=4, SYNC_AMP=16384)
REQ-026 Config nrep=2, win_len=100, trig edge at cycle 10 -> PRE_P cycles 11-18 (isync=16384), PRE_N cycles 19-26 (isync=-16384), rx_srst at 27.
REQ-027 sync_ready at cycle 40 -> GUARD cycles 41-44, rx_srst at 45; second sync_ready at 60 -> done at 61, rep_cnt=2, IDLE at 62.
REQ-028 No sync_ready, win_len=5, nrep=1 -> CAPT exits after 5 cycles, timeout_err=1 until next trigger, done pulses.
REQ-029 Trig edges during PRE_N and CAPT, plus cfg_valid while busy -> no restart, cfg_ready=0, latched config unchanged.
REQ-030 nrep=0 config plus trig edge -> stays IDLE; reset asserted during CAPT -> all outputs at reset values next cycle.
REQ-031 ABORT_EN build, abort during GUARD -> IDLE next cycle, done=0, rx_valid=0.
